// File: rtl/bcd_scan_ctrl.sv
// Scan controller for one shared BCD-to-7-segment decoder: one digit per slot, with blank time and a double-buffered load.
// A load becomes visible one cycle after the next frame boundary. There is no backpressure: a later load overwrites the pending value.
module bcd_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int DIV_MAX      = 50000,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [3:0]            bcd_out,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick,
  output logic                  updated,
  output logic                  pending
);

  localparam int CNT_W = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
  localparam int IDX_W = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [4*N_DIGITS-1:0] r_disp;
  logic [4*N_DIGITS-1:0] r_pend;
  logic                  r_pend_v;
  logic                  r_frame_tick;
  logic                  r_updated;

  logic                  w_slot_end;
  logic                  w_fb;
  logic [3:0]            w_nib;
  logic                  w_zero_run;
  logic [N_DIGITS-1:0]   w_lz;

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_fb       = w_slot_end && (r_idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pend_v     <= 1'b0;
      r_frame_tick <= 1'b0;
      r_updated    <= 1'b0;
    end else begin
      r_frame_tick <= w_fb;
      r_updated    <= 1'b0;
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // disp only moves on the frame boundary so a frame never mixes old and new digits
      if (w_fb) begin
        if (load) begin
          r_disp    <= data_in;
          r_pend_v  <= 1'b0;
          r_updated <= 1'b1;
        end else if (r_pend_v) begin
          r_disp    <= r_pend;
          r_pend_v  <= 1'b0;
          r_updated <= 1'b1;
        end
      end else if (load) begin
        r_pend   <= data_in;
        r_pend_v <= 1'b1;
      end
    end
  end

  always_comb begin
    w_nib = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) w_nib = r_disp[4*k +: 4];
    end
  end

  // digit k is a leading zero when it and every more significant nibble are zero
  always_comb begin
    w_zero_run = 1'b1;
    w_lz       = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run & (r_disp[4*k +: 4] == 4'd0);
      w_lz[k]    = blank_lz & w_zero_run & (k != 0);
    end
  end

  always_comb begin
    an = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if ((r_idx == IDX_W'(k)) && (r_cnt >= CNT_BLANK) && !w_lz[k]) an[k] = 1'b0;
    end
  end

  assign bcd_out    = w_nib;
  assign frame_tick = r_frame_tick;
  assign updated    = r_updated;
  assign pending    = r_pend_v;

endmodule
